// File: rtl/tank_sprite_render_if.sv
// Pixel-stream, tank-state and sprite-ROM signals between the scan generator/mixer and the tank sprite stage.
interface tank_sprite_render_if;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        frame_start;
  logic [9:0]  tank_x;
  logic [9:0]  tank_y;
  logic [1:0]  tank_dir;
  logic        tank_en;
  logic        blink_en;
  logic [11:0] rom_addr;
  logic [11:0] rom_data;
  logic [11:0] sprite_rgb;
  logic        sprite_hit;

  modport master (
    output pixel_x, pixel_y, video_on, frame_start,
    output tank_x, tank_y, tank_dir, tank_en, blink_en,
    output rom_data,
    input  rom_addr, sprite_rgb, sprite_hit
  );

  modport slave (
    input  pixel_x, pixel_y, video_on, frame_start,
    input  tank_x, tank_y, tank_dir, tank_en, blink_en,
    input  rom_data,
    output rom_addr, sprite_rgb, sprite_hit
  );
endinterface

// File: rtl/tank_sprite_render.sv
// Two-stage tank sprite renderer: box test + heading rotation into a ROM address, then colour key / hit.
// Tank state is shadowed once per frame so the sprite cannot tear mid-frame.
module tank_sprite_render #(
  parameter int          SPR_W   = 40,
  parameter logic [11:0] KEY_RGB = 12'h000
) (
  input logic                 clk,
  input logic                 rst_n,
  tank_sprite_render_if.slave bus
);
  localparam logic [5:0]  LAST  = 6'(SPR_W - 1);
  localparam logic [10:0] SPR11 = 11'(SPR_W);

  logic [9:0]  sx_q, sx_d, sy_q, sy_d;
  logic [1:0]  sdir_q, sdir_d;
  logic        sen_q, sen_d, sblink_q, sblink_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [11:0] rom_addr_q, rom_addr_d;
  logic        in_box_q, in_box_d;
  logic [11:0] sprite_rgb_q, sprite_rgb_d;
  logic        sprite_hit_q, sprite_hit_d;

  logic        show, in_box;
  logic [10:0] px11, py11, sx11, sy11;
  logic [5:0]  r, c, row, col;
  logic [11:0] addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q         <= '0;
      sy_q         <= '0;
      sdir_q       <= '0;
      sen_q        <= 1'b0;
      sblink_q     <= 1'b0;
      fcnt_q       <= '0;
      rom_addr_q   <= '0;
      in_box_q     <= 1'b0;
      sprite_rgb_q <= '0;
      sprite_hit_q <= 1'b0;
    end else begin
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      sdir_q       <= sdir_d;
      sen_q        <= sen_d;
      sblink_q     <= sblink_d;
      fcnt_q       <= fcnt_d;
      rom_addr_q   <= rom_addr_d;
      in_box_q     <= in_box_d;
      sprite_rgb_q <= sprite_rgb_d;
      sprite_hit_q <= sprite_hit_d;
    end
  end

  // Frame latch: shadows and blink counter move only on frame_start.
  always_comb begin
    sx_d     = sx_q;
    sy_d     = sy_q;
    sdir_d   = sdir_q;
    sen_d    = sen_q;
    sblink_d = sblink_q;
    fcnt_d   = fcnt_q;
    if (bus.frame_start) begin
      sx_d     = bus.tank_x;
      sy_d     = bus.tank_y;
      sdir_d   = bus.tank_dir;
      sen_d    = bus.tank_en;
      sblink_d = bus.blink_en;
      fcnt_d   = fcnt_q + 4'd1;
    end
  end

  // Stage 1: 11-bit compares so a box hanging off the right/bottom edge clips instead of wrapping.
  always_comb begin
    show   = sen_q & ~(sblink_q & fcnt_q[3]);
    px11   = {1'b0, bus.pixel_x};
    py11   = {1'b0, bus.pixel_y};
    sx11   = {1'b0, sx_q};
    sy11   = {1'b0, sy_q};
    in_box = bus.video_on & show &
             (px11 >= sx11) & (px11 < sx11 + SPR11) &
             (py11 >= sy11) & (py11 < sy11 + SPR11);
    r      = 6'(bus.pixel_y - sy_q);
    c      = 6'(bus.pixel_x - sx_q);
    row    = r;
    col    = c;
    case (sdir_q)
      2'd1: begin row = LAST - c; col = r;        end
      2'd2: begin row = LAST - r; col = LAST - c; end
      2'd3: begin row = c;        col = LAST - r; end
      default: begin row = r;     col = c;        end
    endcase
    addr       = ({6'd0, row} << 5) + ({6'd0, row} << 3) + {6'd0, col};
    rom_addr_d = in_box ? addr : 12'd0;
    in_box_d   = in_box;
  end

  // Stage 2: colour key against the word the ROM returns for last cycle's address.
  always_comb begin
    sprite_hit_d = in_box_q & (bus.rom_data != KEY_RGB);
    sprite_rgb_d = sprite_hit_d ? bus.rom_data : 12'd0;
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.sprite_rgb = sprite_rgb_q;
  assign bus.sprite_hit = sprite_hit_q;
endmodule

// File: tb/tb_tank_sprite_render.sv
// Directed bench for tank_sprite_render: driver queues expected address/pixel results, monitor checks them.
module tb_tank_sprite_render;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  tank_sprite_render_if bus();
  tank_sprite_render dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  logic [11:0] rom [0:1599];
  assign bus.rom_data = (bus.rom_addr < 12'd1600) ? rom[int'(bus.rom_addr)] : 12'hFFF;

  typedef struct {
    int          due;
    logic [11:0] addr;
    logic        hit;
    logic [11:0] rgb;
  } exp_t;

  exp_t aq[$];
  exp_t pq[$];
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int eaddr, input logic ehit);
    exp_t e;
    e.due  = cyc + 1;
    e.addr = 12'(eaddr);
    e.hit  = 1'b0;
    e.rgb  = 12'd0;
    aq.push_back(e);
    e.due  = cyc + 2;
    e.hit  = ehit;
    e.rgb  = ehit ? rom[eaddr] : 12'd0;
    pq.push_back(e);
  endtask

  task automatic pix(input int px, input int py, input logic von, input int eaddr, input logic ehit);
    @(negedge clk);
    bus.frame_start = 1'b0;
    bus.pixel_x     = 10'(px);
    bus.pixel_y     = 10'(py);
    bus.video_on    = von;
    push(eaddr, ehit);
  endtask

  task automatic frame(input int x, input int y, input int d, input logic en, input logic bl,
                       input int px, input int py, input logic von, input int eaddr, input logic ehit);
    @(negedge clk);
    bus.frame_start = 1'b1;
    bus.tank_x      = 10'(x);
    bus.tank_y      = 10'(y);
    bus.tank_dir    = 2'(d);
    bus.tank_en     = en;
    bus.blink_en    = bl;
    bus.pixel_x     = 10'(px);
    bus.pixel_y     = 10'(py);
    bus.video_on    = von;
    push(eaddr, ehit);
  endtask

  // Monitor: one address and one pixel result are due per clock once issued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (aq.size() > 0 && aq[0].due <= cyc) begin
        e = aq.pop_front();
        chk("addr_due", e.due, cyc);
        chk("rom_addr", int'(bus.rom_addr), int'(e.addr));
      end
      if (pq.size() > 0 && pq[0].due <= cyc) begin
        e = pq.pop_front();
        chk("pix_due", e.due, cyc);
        chk("sprite_hit", int'(bus.sprite_hit), int'(e.hit));
        chk("sprite_rgb", int'(bus.sprite_rgb), int'(e.rgb));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1600; i++) rom[i] = 12'(i + 1);
    rom[5] = 12'h000;
    rom[6] = 12'hF80;
    bus.pixel_x = '0; bus.pixel_y = '0; bus.video_on = 1'b0; bus.frame_start = 1'b0;
    bus.tank_x = '0; bus.tank_y = '0; bus.tank_dir = '0; bus.tank_en = 1'b0; bus.blink_en = 1'b0;

    #2 rst_n = 1'b0;
    #3;
    chk("rst_addr", int'(bus.rom_addr), 0);
    chk("rst_hit", int'(bus.sprite_hit), 0);
    chk("rst_rgb", int'(bus.sprite_rgb), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Hidden until the first frame_start enables the tank.
    pix(100, 50, 1, 0, 0);
    pix(100, 50, 1, 0, 0);

    // Up heading, box corners and edges.
    frame(100, 50, 0, 1, 0, 0, 0, 0, 0, 0);
    pix(100, 50, 1, 0, 1);
    pix(139, 89, 1, 1599, 1);
    pix(140, 50, 1, 0, 0);
    pix(100, 50, 0, 0, 0);
    pix(99, 50, 1, 0, 0);
    pix(100, 90, 1, 0, 0);
    // Transparency: addr 5 holds the key colour, addr 6 holds F80.
    pix(105, 50, 1, 5, 0);
    pix(106, 50, 1, 6, 1);

    // Rotation at r=0, c=5.
    frame(100, 50, 1, 1, 0, 0, 0, 0, 0, 0);
    pix(105, 50, 1, 1360, 1);
    frame(100, 50, 2, 1, 0, 0, 0, 0, 0, 0);
    pix(105, 50, 1, 1594, 1);
    frame(100, 50, 3, 1, 0, 0, 0, 0, 0, 0);
    pix(105, 50, 1, 239, 1);

    // Clipping at the bottom-right corner.
    frame(620, 460, 0, 1, 0, 0, 0, 0, 0, 0);
    pix(639, 479, 1, 779, 1);
    pix(0, 479, 1, 0, 0);
    pix(619, 479, 1, 0, 0);

    // Pixel coincident with frame_start uses the old shadow box.
    frame(100, 50, 0, 1, 0, 639, 479, 1, 779, 1);
    pix(639, 479, 1, 0, 0);
    pix(100, 50, 1, 0, 1);

    // Reset mid-line while outputs are showing a hit.
    pix(120, 60, 1, 420, 1);
    pix(120, 60, 1, 420, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    aq.delete();
    pq.delete();
    #1;
    chk("midrst_addr", int'(bus.rom_addr), 0);
    chk("midrst_hit", int'(bus.sprite_hit), 0);
    chk("midrst_rgb", int'(bus.sprite_rgb), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pix(120, 60, 1, 0, 0);
    pix(120, 60, 1, 0, 0);

    // Blink: after frame i the counter is i mod 16; visible while it is below 8.
    for (int i = 1; i <= 16; i++) begin
      frame(100, 50, 0, 1, 1, 0, 0, 0, 0, 0);
      pix(100, 50, 1, 0, (i % 16) < 8);
    end

    // tank_x change without frame_start must not move the sprite.
    @(negedge clk);
    bus.tank_x = 10'd300;
    pix(100, 50, 1, 0, 1);
    pix(300, 50, 1, 0, 0);
    frame(300, 50, 0, 1, 0, 0, 0, 0, 0, 0);
    pix(300, 50, 1, 0, 1);
    pix(100, 50, 1, 0, 0);

    repeat (4) @(negedge clk);
    chk("queue_drain", aq.size() + pq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
